// File: rtl/tx_sym_framer.sv
// rtl/tx_sym_framer.sv - serialises SERVICE/DATA/TAIL/PAD bits of one PSDU into OFDM-symbol sized groups
module tx_sym_framer (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_start,
    input  logic [7:0]  i_pkt_rate,
    input  logic [15:0] i_pkt_len,
    input  logic [7:0]  i_byte_in,
    input  logic        i_byte_in_valid,
    output logic        o_byte_in_ready,
    output logic        o_bit_out,
    output logic        o_bit_out_valid,
    input  logic        i_bit_out_ready,
    output logic        o_sym_start,
    output logic        o_last_sym,
    output logic [15:0] o_sym_cnt,
    output logic        o_done,
    output logic        o_rate_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SERVICE = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_TAIL    = 3'd3;
    localparam logic [2:0] S_PAD     = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]  r_state;
    logic [8:0]  r_n_dbps;
    logic [15:0] r_pkt_len;
    logic [19:0] r_target;
    logic [8:0]  r_sym_bit_cnt;
    logic [19:0] r_emitted;
    logic [15:0] r_sym_cnt;
    logic [15:0] r_bytes_fetched;
    logic [7:0]  r_buf;
    logic        r_buf_full;
    logic [2:0]  r_bit_idx;
    logic [3:0]  r_phase_cnt;
    logic        r_last_sym;
    logic        r_rate_err;

    logic [8:0]  w_lut_dbps;
    logic        w_zero_bit_state;
    logic        w_valid;
    logic        w_xfer;
    logic        w_sym_first;
    logic        w_sym_last;
    logic        w_last_calc;

    // The whole rate byte is decoded so HT codes with bit 3 set fall to 0.
    always_comb begin
        w_lut_dbps = 9'd0;
        casez (i_pkt_rate)
            8'b0???_1011: w_lut_dbps = 9'd24;
            8'b0???_1111: w_lut_dbps = 9'd36;
            8'b0???_1010: w_lut_dbps = 9'd48;
            8'b0???_1110: w_lut_dbps = 9'd72;
            8'b0???_1001: w_lut_dbps = 9'd96;
            8'b0???_1101: w_lut_dbps = 9'd144;
            8'b0???_1000: w_lut_dbps = 9'd192;
            8'b0???_1100: w_lut_dbps = 9'd216;
            8'b1???_0000: w_lut_dbps = 9'd26;
            8'b1???_0001: w_lut_dbps = 9'd52;
            8'b1???_0010: w_lut_dbps = 9'd78;
            8'b1???_0011: w_lut_dbps = 9'd104;
            8'b1???_0100: w_lut_dbps = 9'd156;
            8'b1???_0101: w_lut_dbps = 9'd208;
            8'b1???_0110: w_lut_dbps = 9'd234;
            8'b1???_0111: w_lut_dbps = 9'd260;
            default:      w_lut_dbps = 9'd0;
        endcase
    end

    // PAD with a freshly completed symbol has nothing left to send.
    assign w_zero_bit_state = (r_state == S_SERVICE) || (r_state == S_TAIL) ||
                              ((r_state == S_PAD) && (r_sym_bit_cnt != 9'd0));
    assign w_valid     = i_enable && (w_zero_bit_state || ((r_state == S_DATA) && r_buf_full));
    assign w_xfer      = w_valid && i_bit_out_ready;
    assign w_sym_first = (r_sym_bit_cnt == 9'd0);
    assign w_sym_last  = (r_sym_bit_cnt == (r_n_dbps - 9'd1));
    assign w_last_calc = ({1'b0, r_target} <= ({1'b0, r_emitted} + {12'd0, r_n_dbps}));

    assign o_bit_out_valid = w_valid;
    assign o_bit_out       = w_valid && (r_state == S_DATA) && r_buf[0];
    assign o_sym_start     = w_valid && w_sym_first;
    assign o_last_sym      = w_valid && (w_sym_first ? w_last_calc : r_last_sym);
    assign o_byte_in_ready = i_enable && (r_state == S_DATA) && !r_buf_full &&
                             (r_bytes_fetched < r_pkt_len);
    assign o_sym_cnt       = r_sym_cnt;
    assign o_done          = i_enable && (r_state == S_DONE);
    assign o_rate_err      = r_rate_err;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state         <= S_IDLE;
            r_n_dbps        <= 9'd0;
            r_pkt_len       <= 16'd0;
            r_target        <= 20'd0;
            r_sym_bit_cnt   <= 9'd0;
            r_emitted       <= 20'd0;
            r_sym_cnt       <= 16'd0;
            r_bytes_fetched <= 16'd0;
            r_buf           <= 8'd0;
            r_buf_full      <= 1'b0;
            r_bit_idx       <= 3'd0;
            r_phase_cnt     <= 4'd0;
            r_last_sym      <= 1'b0;
            r_rate_err      <= 1'b0;
        end else begin
            r_rate_err <= 1'b0;
            if (i_enable) begin
                if (w_xfer) begin
                    r_emitted <= r_emitted + 20'd1;
                    if (w_sym_first)
                        r_last_sym <= w_last_calc;
                    if (w_sym_last) begin
                        r_sym_bit_cnt <= 9'd0;
                        r_sym_cnt     <= r_sym_cnt + 16'd1;
                    end else begin
                        r_sym_bit_cnt <= r_sym_bit_cnt + 9'd1;
                    end
                end
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            if (w_lut_dbps != 9'd0) begin
                                r_n_dbps        <= w_lut_dbps;
                                r_pkt_len       <= i_pkt_len;
                                r_target        <= {1'b0, i_pkt_len, 3'b000} + 20'd22;
                                r_sym_bit_cnt   <= 9'd0;
                                r_emitted       <= 20'd0;
                                r_sym_cnt       <= 16'd0;
                                r_bytes_fetched <= 16'd0;
                                r_buf_full      <= 1'b0;
                                r_bit_idx       <= 3'd0;
                                r_phase_cnt     <= 4'd0;
                                r_last_sym      <= 1'b0;
                                r_state         <= S_SERVICE;
                            end else begin
                                r_rate_err <= 1'b1;
                            end
                        end
                    end
                    S_SERVICE: begin
                        if (w_xfer) begin
                            r_phase_cnt <= r_phase_cnt + 4'd1;
                            if (r_phase_cnt == 4'd15)
                                r_state <= (r_pkt_len == 16'd0) ? S_TAIL : S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (o_byte_in_ready && i_byte_in_valid) begin
                            r_buf           <= i_byte_in;
                            r_buf_full      <= 1'b1;
                            r_bytes_fetched <= r_bytes_fetched + 16'd1;
                        end
                        if (w_xfer) begin
                            r_buf     <= {1'b0, r_buf[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                            if (r_bit_idx == 3'd7) begin
                                r_buf_full <= 1'b0;
                                if (r_bytes_fetched == r_pkt_len)
                                    r_state <= S_TAIL;
                            end
                        end
                    end
                    S_TAIL: begin
                        if (w_xfer) begin
                            if (r_phase_cnt == 4'd5) begin
                                r_phase_cnt <= 4'd0;
                                r_state     <= S_PAD;
                            end else begin
                                r_phase_cnt <= r_phase_cnt + 4'd1;
                            end
                        end
                    end
                    S_PAD: begin
                        if (w_sym_first || (w_xfer && w_sym_last))
                            r_state <= S_DONE;
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_sym_framer.sv
// tb/tb_tx_sym_framer.sv - scoreboard bench for tx_sym_framer
module tb_tx_sym_framer;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_enable = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_pkt_rate = 8'd0;
    logic [15:0] i_pkt_len = 16'd0;
    logic [7:0]  i_byte_in = 8'd0;
    logic        i_byte_in_valid = 1'b0;
    logic        o_byte_in_ready;
    logic        o_bit_out;
    logic        o_bit_out_valid;
    logic        i_bit_out_ready = 1'b1;
    logic        o_sym_start;
    logic        o_last_sym;
    logic [15:0] o_sym_cnt;
    logic        o_done;
    logic        o_rate_err;

    always #5 clk = ~clk;

    tx_sym_framer dut (
        .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_start(i_start),
        .i_pkt_rate(i_pkt_rate), .i_pkt_len(i_pkt_len), .i_byte_in(i_byte_in),
        .i_byte_in_valid(i_byte_in_valid), .o_byte_in_ready(o_byte_in_ready),
        .o_bit_out(o_bit_out), .o_bit_out_valid(o_bit_out_valid),
        .i_bit_out_ready(i_bit_out_ready), .o_sym_start(o_sym_start),
        .o_last_sym(o_last_sym), .o_sym_cnt(o_sym_cnt), .o_done(o_done),
        .o_rate_err(o_rate_err)
    );

    typedef struct {
        logic b;
        logic ss;
        logic ls;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] byte_q[$];
    int         total = 0;
    int         bad = 0;
    int         done_cnt = 0;
    int         rerr_cnt = 0;
    int         valid_cnt = 0;
    int         popped = 0;
    logic       rnd_mode = 1'b0;
    logic       feed_hs = 1'b0;
    logic       prev_stall = 1'b0;
    logic [2:0] prev_out = 3'd0;
    int         gap = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted bit.
    always @(negedge clk) begin
        feed_hs = i_byte_in_valid && o_byte_in_ready && !i_reset;
        if (!i_reset) begin
            if (prev_stall)
                check("stall_hold", {o_bit_out_valid, o_bit_out, o_sym_start, o_last_sym},
                      {1'b1, prev_out});
            if (o_byte_in_ready)
                check("valid_while_empty", o_bit_out_valid, 0);
            if (o_done) done_cnt++;
            if (o_rate_err) rerr_cnt++;
            if (o_bit_out_valid) valid_cnt++;
            if (o_bit_out_valid && i_bit_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_bit", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check($sformatf("bit%0d", popped), {o_bit_out, o_sym_start, o_last_sym},
                          {e.b, e.ss, e.ls});
                    popped++;
                end
            end
            prev_stall = o_bit_out_valid && !i_bit_out_ready;
            prev_out   = {o_bit_out, o_sym_start, o_last_sym};
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            i_bit_out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (feed_hs) begin
                if (byte_q.size() > 0) void'(byte_q.pop_front());
                i_byte_in_valid = 1'b0;
                gap = rnd_mode ? int'($urandom_range(0, 5)) : 0;
            end else if (!i_byte_in_valid && byte_q.size() > 0) begin
                if (gap == 0) begin
                    i_byte_in       = byte_q[0];
                    i_byte_in_valid = 1'b1;
                end else begin
                    gap--;
                end
            end
        end
    end

    task automatic push_exp(input int len, input int n);
        int target;
        int tot;
        target = 8 * len + 22;
        tot = ((target + n - 1) / n) * n;
        for (int i = 0; i < tot; i++) begin
            exp_t e;
            logic [7:0] by;
            e.b = 1'b0;
            if (i >= 16 && i < 16 + 8 * len) begin
                by  = byte_q[(i - 16) / 8];
                e.b = by[(i - 16) % 8];
            end
            e.ss = ((i % n) == 0);
            e.ls = (i >= tot - n);
            exp_q.push_back(e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input logic [7:0] rate, input int len);
        i_pkt_rate = rate;
        i_pkt_len  = 16'(len);
        i_start    = 1'b1;
        cyc();
        i_start    = 1'b0;
    endtask

    task automatic run_pkt(input string name, input logic [7:0] rate, input int len, input int n,
                           input int exp_bits, input int exp_syms, input bit restart);
        int d0;
        int p0;
        d0 = done_cnt;
        p0 = popped;
        push_exp(len, n);
        pulse_start(rate, len);
        if (restart) begin
            repeat (4) cyc();
            pulse_start(8'h87, 7);
        end
        for (int c = 0; c < 5000 && done_cnt == d0; c++) cyc();
        repeat (3) cyc();
        check({name, "_done"}, done_cnt - d0, 1);
        check({name, "_bits"}, popped - p0, exp_bits);
        check({name, "_left"}, exp_q.size(), 0);
        check({name, "_sym_cnt"}, o_sym_cnt, exp_syms);
        exp_q.delete();
    endtask

    initial begin
        int d0;
        int r0;
        int v0;
        int p0;
        repeat (3) cyc();
        check("reset_outputs", {o_byte_in_ready, o_bit_out, o_bit_out_valid, o_sym_start,
                                o_last_sym, o_sym_cnt, o_done, o_rate_err}, 0);
        i_reset = 1'b0;
        cyc();

        run_pkt("len0", 8'h0B, 0, 24, 24, 1, 1'b0);

        byte_q.push_back(8'hA5);
        run_pkt("len1", 8'h0B, 1, 24, 48, 2, 1'b1);

        for (int i = 0; i < 100; i++) byte_q.push_back(8'((i * 37 + 11) & 8'hFF));
        run_pkt("ht7", 8'h87, 100, 260, 1040, 4, 1'b0);

        rnd_mode = 1'b1;
        byte_q.push_back(8'h3C);
        byte_q.push_back(8'h81);
        byte_q.push_back(8'hFF);
        run_pkt("bp3", 8'h0B, 3, 24, 48, 2, 1'b0);
        for (int i = 0; i < 5; i++) byte_q.push_back(8'h5A ^ 8'(i * 3));
        run_pkt("bp5", 8'h0F, 5, 36, 72, 2, 1'b0);
        rnd_mode = 1'b0;
        repeat (2) cyc();

        d0 = done_cnt;
        r0 = rerr_cnt;
        v0 = valid_cnt;
        pulse_start(8'h05, 4);
        repeat (20) cyc();
        check("rate_err_pulse", rerr_cnt - r0, 1);
        check("rate_err_no_valid", valid_cnt - v0, 0);
        check("rate_err_no_done", done_cnt - d0, 0);
        check("rate_err_sym_cnt", o_sym_cnt, 2);

        for (int i = 0; i < 100; i++) byte_q.push_back(8'(i));
        p0 = popped;
        push_exp(100, 260);
        pulse_start(8'h87, 100);
        for (int c = 0; c < 2000 && (popped - p0) < 30; c++) cyc();
        check("abort_reached", (popped - p0) >= 30, 1);
        i_reset = 1'b1;
        cyc();
        check("abort_reset_outputs", {o_byte_in_ready, o_bit_out, o_bit_out_valid, o_sym_start,
                                      o_last_sym, o_sym_cnt, o_done, o_rate_err}, 0);
        exp_q.delete();
        byte_q.delete();
        i_byte_in_valid = 1'b0;
        cyc();
        i_reset = 1'b0;
        cyc();
        run_pkt("after_abort", 8'h0B, 0, 24, 24, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_sym_framer.md
TX_SYM_FRAMER -- requirements
Module: tx_sym_framer

Interface
REQ-001 SHALL have no parameters.
REQ-002 clock  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 enable  in  1  high: normal operation; low: all state frozen and bit_out_valid forced 0.
REQ-005 start  in  1  one-cycle pulse; begins a packet when in IDLE.
REQ-006 pkt_rate  in  8  sampled on start; bit[7]=1 means HT, bits[3:0] give the rate/MCS code.
REQ-007 pkt_len  in  16  PSDU length in bytes, sampled on start.
REQ-008 byte_in  in  8  PSDU data byte.
REQ-009 byte_in_valid  in  1  byte_in holds a valid byte.
REQ-010 byte_in_ready  out  1  block accepts byte_in this cycle; a transfer occurs when valid and ready are both high.
REQ-011 bit_out  out  1  serial DATA-field bit to the scrambler.
REQ-012 bit_out_valid  out  1  bit_out is valid.
REQ-013 bit_out_ready  in  1  downstream accepts bit; a transfer occurs when valid and ready are both high.
REQ-014 sym_start  out  1  high with the first bit of each OFDM symbol.
REQ-015 last_sym  out  1  high with every bit of the final OFDM symbol.
REQ-016 sym_cnt  out  16  number of completed symbols in the current packet.
REQ-017 done  out  1  one-cycle pulse after the final bit transfers.
REQ-018 rate_err  out  1  one-cycle pulse when start carries an unsupported rate.

Function
REQ-019 n_dbps SHALL be looked up from {pkt_rate[7], pkt_rate[3:0]} and latched on start.
- Non-HT: 1011=24, 1111=36, 1010=48, 1110=72, 1001=96, 1101=144, 1000=192, 1100=216.
- HT MCS0-7: 26, 52, 78, 104, 156, 208, 234, 260.
- All other codes: 0.
REQ-020 States SHALL be IDLE, SERVICE, DATA, TAIL, PAD, DONE.
REQ-021 IDLE with start and n_dbps≠0 SHALL go to SERVICE.
REQ-022 IDLE with start and n_dbps=0 SHALL pulse rate_err for one cycle, emit no bits and stay in IDLE.
REQ-023 start SHALL be ignored outside IDLE.
REQ-024 SERVICE SHALL emit 16 zero bits, then go to DATA, or to TAIL when pkt_len=0.
REQ-025 DATA SHALL emit pkt_len bytes, LSB first, then go to TAIL.
REQ-026 TAIL SHALL emit 6 zero bits, then go to PAD.
REQ-027 PAD SHALL emit zero bits until the current symbol holds n_dbps bits, then go to DONE.
- Zero pad bits is legal: PAD then exits immediately.
REQ-028 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-029 Byte buffer rules:
- One 8-bit buffer with a full flag.
- byte_in_ready = (state==DATA) AND buffer empty AND bytes_fetched < pkt_len.
- The buffer empties when its 8th bit transfers.
- In DATA, bit_out_valid SHALL be 0 while the buffer is empty.
REQ-030 Outside DATA, in any active state with enable=1, bit_out_valid SHALL be 1.
REQ-031 bit_out, sym_start and last_sym SHALL be held stable while bit_out_valid=1 and bit_out_ready=0.
REQ-032 Counters SHALL advance only on bit transfer:
- sym_bit_cnt (9 bits) counts bits within the current symbol.
- emitted (20 bits) counts bits in the packet.
- sym_cnt increments when sym_bit_cnt reaches n_dbps-1 on a transfer; sym_bit_cnt then wraps to 0.
REQ-033 target SHALL equal 8*pkt_len + 22, computed in 20 bits.
REQ-034 At each symbol's first bit, last_sym SHALL be set if target <= emitted + n_dbps (21-bit compare), and held for that whole symbol.
REQ-035 Total bits emitted SHALL equal ceil(target/n_dbps)*n_dbps.
REQ-036 Implementation SHALL use no divider.

Reset
REQ-037 On reset the block SHALL go to IDLE.
REQ-038 On reset the following SHALL be 0: byte_in_ready, bit_out, bit_out_valid, sym_start, last_sym, sym_cnt, done, rate_err, and all counters; the buffer SHALL be empty.
REQ-039 Reset mid-packet SHALL abort the packet; outputs SHALL be at reset values the next cycle.
REQ-040 sym_cnt SHALL hold after DONE and clear on the next accepted start.

Verification
REQ-041 rate 0x0B, len 0, ready=1 -> 24 bits, all 0 (16 service, 6 tail, 2 pad); sym_start on bit 0; last_sym on bits 0-23; sym_cnt=1; one done pulse.
REQ-042 rate 0x0B, len 1, byte 0xA5 -> 48 bits; bits 16-23 = 1,0,1,0,0,1,0,1; sym_start on bits 0 and 24; last_sym on bits 24-47 only; sym_cnt=2.
REQ-043 rate 0x87 (HT MCS7), len 100 -> 1040 bits (4 symbols, 218 pad); last_sym only on the 4th symbol; sym_cnt=4.
REQ-044 Backpressure: random bit_out_ready, byte_in_valid delayed 0-5 cycles, rate 0x0B, len 3 -> bit stream matches the no-stall reference; no bit lost or duplicated; valid low while the buffer is empty.
REQ-045 start with rate 0x05 -> rate_err for 1 cycle; bit_out_valid stays 0; done never asserts.
REQ-046 Reset at bit 30 of the REQ-043 packet -> outputs at reset values the next cycle; a following start (rate 0x0B, len 0) produces exactly the REQ-041 response.
